// File: rtl/fpu_bus_bridge_pkg.sv
// rtl/fpu_bus_bridge_pkg.sv - shared FPU opcode type plus bridge states, register map and status bits
package pa_fpu;

  typedef enum logic [3:0] {
    op_add  = 4'd0,
    op_sub  = 4'd1,
    op_mul  = 4'd2,
    op_div  = 4'd3,
    op_sqrt = 4'd4,
    op_f2i  = 4'd5,
    op_i2f  = 4'd6,
    op_cmp  = 4'd7
  } e_fpu_op;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } e_fpu_bridge_state;

  localparam logic [3:0] ADDR_A0     = 4'h0;
  localparam logic [3:0] ADDR_B0     = 4'h4;
  localparam logic [3:0] ADDR_CMD    = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'h9;
  localparam logic [3:0] ADDR_RES0   = 4'hC;

  localparam int STAT_PEND = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_TMO  = 2;
  localparam int STAT_ERR  = 3;

endpackage

// File: rtl/fpu_bus_bridge_if.sv
// rtl/fpu_bus_bridge_if.sv - 8-bit register-mapped CPU peripheral bus
interface fpu_bus_bridge_if;
  logic [3:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output addr, output wr, output rd, output wdata, input rdata);
  modport slave  (input addr, input wr, input rd, input wdata, output rdata);
endinterface

// File: rtl/fpu_bus_bridge.sv
// rtl/fpu_bus_bridge.sv - CPU bus responder that issues FPU commands and serves their results
module fpu_bus_bridge
  import pa_fpu::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   arst_n,
  fpu_bus_bridge_if.slave        bus,
  output logic                   irq,
  output logic [31:0]            fpu_a_operand,
  output logic [31:0]            fpu_b_operand,
  output e_fpu_op                fpu_operation,
  output logic                   fpu_start,
  input  logic [31:0]            fpu_result,
  input  logic                   fpu_cmd_end,
  input  logic                   fpu_busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  e_fpu_bridge_state state;
  logic [31:0]       a_reg;
  logic [31:0]       b_reg;
  logic [31:0]       result_reg;
  e_fpu_op           op_reg;
  logic              pend;
  logic              done;
  logic              tmo;
  logic              err;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        rdata_reg;
  logic [7:0]        rd_mux;
  logic [4:0]        byte_lsb;
  logic              wr_locked;

  // fpu_busy carries no information the bridge needs beyond cmd_end
  logic unused_inputs;
  assign unused_inputs = fpu_busy;

  assign byte_lsb  = {bus.addr[1:0], 3'b000};
  assign wr_locked = pend && (bus.addr <= ADDR_CMD);

  assign fpu_a_operand = a_reg;
  assign fpu_b_operand = b_reg;
  assign fpu_operation = op_reg;
  assign bus.rdata     = rdata_reg;
  assign irq           = done | tmo;

  // Read data selection over the register map
  always_comb begin
    rd_mux = 8'h00;
    case (bus.addr)
      4'h0, 4'h1, 4'h2, 4'h3: rd_mux = a_reg[byte_lsb +: 8];
      4'h4, 4'h5, 4'h6, 4'h7: rd_mux = b_reg[byte_lsb +: 8];
      ADDR_CMD:               rd_mux = {4'b0000, op_reg};
      ADDR_STATUS:            rd_mux = {4'b0000, err, tmo, done, pend};
      4'hC, 4'hD, 4'hE, 4'hF: rd_mux = result_reg[byte_lsb +: 8];
      default:                rd_mux = 8'h00;
    endcase
  end

  // Bus register writes, read data capture and the command FSM; FSM updates come last so status sets beat clears
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      op_reg     <= op_add;
      pend       <= 1'b0;
      done       <= 1'b0;
      tmo        <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      fpu_start  <= 1'b0;
      rdata_reg  <= 8'h00;
    end else begin
      if (bus.rd && !bus.wr) begin
        rdata_reg <= rd_mux;
      end

      if (bus.wr) begin
        if (wr_locked) begin
          err <= 1'b1;
        end else begin
          case (bus.addr)
            4'h0, 4'h1, 4'h2, 4'h3: a_reg[byte_lsb +: 8] <= bus.wdata;
            4'h4, 4'h5, 4'h6, 4'h7: b_reg[byte_lsb +: 8] <= bus.wdata;
            ADDR_CMD: begin
              op_reg <= e_fpu_op'(bus.wdata[3:0]);
              pend   <= 1'b1;
              done   <= 1'b0;
              state  <= ST_ISSUE;
            end
            ADDR_STATUS: begin
              if (bus.wdata[STAT_DONE]) done <= 1'b0;
              if (bus.wdata[STAT_TMO])  tmo  <= 1'b0;
              if (bus.wdata[STAT_ERR])  err  <= 1'b0;
            end
            default: ;
          endcase
        end
      end

      case (state)
        ST_ISSUE: begin
          fpu_start <= 1'b1;
          cnt       <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fpu_cmd_end) begin
            fpu_start  <= 1'b0;
            result_reg <= fpu_result;
            done       <= 1'b1;
            pend       <= 1'b0;
            state      <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            fpu_start <= 1'b0;
            tmo       <= 1'b1;
            pend      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
